aes128_round_ctrl: RTL



---
 rtl/aes_pkg.sv | 75 +++++++
 rtl/aes_key_step.sv | 30 +++
 rtl/aes_mix_columns.sv | 31 +++
 rtl/aes128_round_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers
// for the iterative round controller and its key schedule.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_e;

  typedef logic [127:0] blk_t;

  localparam int         NR        = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Byte v lives at bits [2047-8v -: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    logic [10:0] idx;
    idx = ~{b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic blk_t sub_bytes(
    input blk_t s
  );
    return {sub_word(s[127:96]), sub_word(s[95:64]),
            sub_word(s[63:32]),  sub_word(s[31:0])};
  endfunction

  // Byte b = s[127-8b -: 8]; row r of column c is byte 4c+r
  function automatic blk_t shift_rows(
    input blk_t s
  );
    return {s[127:120], s[87:80],   s[47:40],  s[7:0],
            s[95:88],   s[55:48],   s[15:8],   s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],  s[39:32]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next
// round key from the current key and round constant.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, tmp;
  logic [31:0] n0, n1, n2, n3;

  assign w0  = key[127:96];
  assign w1  = key[95:64];
  assign w2  = key[63:32];
  assign w3  = key[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign tmp = sub_word(rot) ^ {rcon, 24'h000000};

  assign n0  = w0 ^ tmp;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_mix_columns.sv
// MixColumns over all four state columns; purely
// combinational.
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  function automatic logic [31:0] mix_col(
    input logic [31:0] w
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  assign state_o = {mix_col(state_i[127:96]),
                    mix_col(state_i[95:64]),
                    mix_col(state_i[63:32]),
                    mix_col(state_i[31:0])};

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock,
// on-the-fly key schedule, valid/ready on both sides.
module aes128_round_ctrl
  import aes_pkg::*;
#(
  parameter int         NR        = aes_pkg::NR,
  parameter logic [7:0] RCON_INIT = aes_pkg::RCON_INIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   round_idx
);

  if (NR != 10) begin : g_bad_nr
    $error("aes128_round_ctrl: NR must be 10");
  end

  localparam logic [3:0] LAST_MIX = 4'(NR - 1);

  fsm_e        state_q, state_d;
  blk_t        blk_q, blk_d;
  blk_t        key_q, key_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  round_q, round_d;
  logic        ovld_q, ovld_d;
  blk_t        oblk_q, oblk_d;

  blk_t        next_key;
  blk_t        sr;
  blk_t        mc;
  blk_t        rnd;

  aes_key_step u_key_step (
    .key      (key_q),
    .rcon     (rcon_q),
    .next_key (next_key)
  );

  assign sr = shift_rows(sub_bytes(blk_q));

  aes_mix_columns u_mix (
    .state_i (sr),
    .state_o (mc)
  );

  // Final round skips MixColumns
  assign rnd = ((state_q == FINAL) ? sr : mc)
             ^ next_key;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      rcon_q  <= RCON_INIT;
      round_q <= '0;
      ovld_q  <= 1'b0;
      oblk_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      ovld_q  <= ovld_d;
      oblk_q  <= oblk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (in_valid) state_d = ROUND;
      ROUND:
        if (round_q == LAST_MIX) state_d = FINAL;
      FINAL:
        state_d = DONE;
      DONE:
        if (out_ready) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    blk_d   = blk_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    ovld_d  = ovld_q;
    oblk_d  = oblk_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (in_valid) begin
          blk_d   = in_block ^ in_key;
          key_d   = in_key;
          rcon_d  = RCON_INIT;
          round_d = 4'd1;
        end
      end
      (state_q == ROUND): begin
        blk_d   = rnd;
        key_d   = next_key;
        rcon_d  = xtime(rcon_q);
        round_d = round_q + 4'd1;
      end
      (state_q == FINAL): begin
        blk_d   = rnd;
        key_d   = next_key;
        rcon_d  = xtime(rcon_q);
        round_d = 4'd0;
        oblk_d  = rnd;
        ovld_d  = 1'b1;
      end
      (state_q == DONE): begin
        if (out_ready) ovld_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ovld_q;
  assign out_block = oblk_q;
  assign round_idx = round_q;

endmodule
